// File: rtl/shared_res_pkg.sv
// Shared types for the two-requester resource scheduler: requester id and the
// per-issue tag that travels through the in-flight FIFO.
package shared_res_pkg;

    localparam int N_REQ = 2;

    typedef logic [0:0] req_id_t;

    typedef struct packed {
        req_id_t id;
        logic    kill;
    } sched_tag_t;

    function automatic sched_tag_t make_tag(input req_id_t id);
        sched_tag_t t;
        t.id   = id;
        t.kill = 1'b0;
        return t;
    endfunction

endpackage

// File: rtl/sched_tag_fifo.sv
// Circular FIFO of issue tags, one entry per op in flight. A per-requester kill
// broadcast marks every stored entry of that requester as dead.
module sched_tag_fifo
    import shared_res_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  sched_tag_t       push_tag,
    input  logic             pop,
    input  logic [N_REQ-1:0] kill_en,
    output sched_tag_t       head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FILL  = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    sched_tag_t       mem [DEPTH];

    logic push_ok;
    logic pop_ok;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == FILL);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= bump(wr_ptr);
            if (pop_ok)  rd_ptr <= bump(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Kill marks may land on stale slots too; those are rewritten before they are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en[mem[i].id]) mem[i].kill <= 1'b1;
        end
        if (push_ok) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/shared_resource_scheduler.sv
// Round-robin issue scheduler for one pipelined shared resource and two requesters,
// with credit-bounded issue and tag-based steering of results back to their owner.
module shared_resource_scheduler
    import shared_res_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] flush,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] stall,
    output logic             sel,
    output logic             res_in_valid,
    input  logic             res_out_valid,
    output logic [N_REQ-1:0] rsp_valid,
    output logic             busy,
    output logic             err_underflow
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic             prio;
    logic [CNT_W-1:0] credits;
    logic             err_q;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant_raw;
    logic [N_REQ-1:0] rsp_raw;
    logic             can_issue;
    logic             issue;
    logic             pop;

    sched_tag_t       head;
    logic             fifo_full;
    logic             fifo_empty;

    assign elig      = req & ~flush;
    // Full FIFO already implies zero credits; the extra term keeps the FIFO safe on its own.
    assign can_issue = (credits != '0) & ~fifo_full;
    assign issue     = |grant_raw;
    assign pop       = res_out_valid & ~fifo_empty;

    always_comb begin
        grant_raw = '0;
        if (can_issue) begin
            if (&elig) grant_raw[prio] = 1'b1;
            else       grant_raw       = elig;
        end
    end

    always_comb begin
        rsp_raw = '0;
        if (pop) rsp_raw[head.id] = ~head.kill & ~flush[head.id];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio    <= 1'b0;
            credits <= CREDIT_MAX;
            err_q   <= 1'b0;
        end else begin
            // Priority passes to whichever requester was not granted.
            if (issue) prio <= grant_raw[0];
            case ({issue, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
            if (res_out_valid & fifo_empty) err_q <= 1'b1;
        end
    end

    sched_tag_fifo #(
        .DEPTH    (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (issue),
        .push_tag (make_tag(req_id_t'(grant_raw[1]))),
        .pop      (pop),
        .kill_en  (flush),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign grant         = reset ? grant_raw : '0;
    assign stall         = reset ? (elig & ~grant_raw) : '0;
    assign sel           = reset & grant_raw[1];
    assign res_in_valid  = reset & issue;
    assign rsp_valid     = reset ? rsp_raw : '0;
    assign busy          = reset & (credits != CREDIT_MAX);
    assign err_underflow = reset & err_q;

endmodule

// File: tb/tb_shared_resource_scheduler.sv
// Directed bench for shared_resource_scheduler: a queue-based reference model checked
// every cycle, plus hand-computed per-cycle expectations on the key vectors.
module tb_shared_resource_scheduler;
    import shared_res_pkg::*;

    localparam int MAX = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req   = 2'b00;
    logic [1:0] flush = 2'b00;
    logic       rov   = 1'b0;
    logic [1:0] grant, stall, rsp_valid;
    logic       sel, res_in_valid, busy, err_underflow;

    always #5 clk = ~clk;

    shared_resource_scheduler #(.MAX_OUTSTANDING(MAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .flush         (flush),
        .grant         (grant),
        .stall         (stall),
        .sel           (sel),
        .res_in_valid  (res_in_valid),
        .res_out_valid (rov),
        .rsp_valid     (rsp_valid),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    // Reference model: ops in flight as a queue of (owner, dead) pairs.
    typedef struct {
        bit id;
        bit kill;
    } mtag_t;

    mtag_t      q[$];
    int         m_ptr     = 0;
    int         m_credits = MAX;
    bit         m_err     = 0;
    logic [1:0] e_grant   = 2'b00;

    int tests = 0;
    int fails = 0;

    logic       pin_on = 1'b0;
    logic [1:0] pin_grant, pin_stall, pin_rsp;
    logic       pin_busy, pin_err;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] elig, g, rsp;
        elig = req & ~flush;
        g    = 2'b00;
        rsp  = 2'b00;
        if (reset && m_credits > 0) begin
            if (elig == 2'b11) g = (m_ptr == 0) ? 2'b01 : 2'b10;
            else               g = elig;
        end
        if (reset && rov && q.size() > 0) begin
            if (!q[0].kill && !flush[q[0].id]) rsp[q[0].id] = 1'b1;
        end
        e_grant = g;
        chk("grant", grant, g);
        chk("stall", stall, reset ? (elig & ~g) : 2'b00);
        chk("sel", {1'b0, sel}, {1'b0, g[1]});
        chk("res_in_valid", {1'b0, res_in_valid}, {1'b0, |g});
        chk("rsp_valid", rsp_valid, rsp);
        chk("busy", {1'b0, busy}, {1'b0, reset && (m_credits != MAX)});
        chk("err_underflow", {1'b0, err_underflow}, {1'b0, reset && m_err});
        if (pin_on) begin
            chk("pin_grant", grant, pin_grant);
            chk("pin_stall", stall, pin_stall);
            chk("pin_rsp_valid", rsp_valid, pin_rsp);
            chk("pin_busy", {1'b0, busy}, {1'b0, pin_busy});
            chk("pin_err", {1'b0, err_underflow}, {1'b0, pin_err});
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            m_ptr     = 0;
            m_credits = MAX;
            m_err     = 0;
        end else begin
            if (rov) begin
                if (q.size() == 0) begin
                    m_err = 1;
                end else begin
                    void'(q.pop_front());
                    m_credits++;
                end
            end
            foreach (q[k]) if (flush[q[k].id]) q[k].kill = 1;
            if (e_grant != 2'b00) begin
                q.push_back('{id: e_grant[1], kill: 1'b0});
                m_credits--;
                m_ptr = e_grant[0] ? 1 : 0;
            end
        end
    end

    task automatic cyc(input logic rs, input logic [1:0] r, input logic [1:0] f, input logic rv);
        @(posedge clk);
        #1;
        pin_on = 1'b0;
        reset  = rs;
        req    = r;
        flush  = f;
        rov    = rv;
        #2;
    endtask

    task automatic pin(input logic [1:0] g, input logic [1:0] s, input logic [1:0] r,
                       input logic b, input logic e);
        pin_grant = g;
        pin_stall = s;
        pin_rsp   = r;
        pin_busy  = b;
        pin_err   = e;
        pin_on    = 1'b1;
    endtask

    initial begin
        #1 reset = 1'b0;

        // Held in reset: everything quiet even with requests and a stray result.
        cyc(0, 2'b11, 2'b00, 0); pin(2'b00, 2'b00, 2'b00, 0, 0);
        cyc(0, 2'b11, 2'b00, 1); pin(2'b00, 2'b00, 2'b00, 0, 0);

        // Both requesting, results two cycles after issue.
        cyc(1, 2'b11, 2'b00, 0); pin(2'b01, 2'b10, 2'b00, 0, 0);
        cyc(1, 2'b11, 2'b00, 0); pin(2'b10, 2'b01, 2'b00, 1, 0);
        cyc(1, 2'b11, 2'b00, 1); pin(2'b01, 2'b10, 2'b01, 1, 0);
        cyc(1, 2'b11, 2'b00, 1); pin(2'b10, 2'b01, 2'b10, 1, 0);
        cyc(1, 2'b11, 2'b00, 1); pin(2'b01, 2'b10, 2'b01, 1, 0);
        cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b10, 1, 0);
        cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b01, 1, 0);

        // Credit exhaustion with a single requester.
        cyc(1, 2'b01, 2'b00, 0); pin(2'b01, 2'b00, 2'b00, 0, 0);
        cyc(1, 2'b01, 2'b00, 0);
        cyc(1, 2'b01, 2'b00, 0);
        cyc(1, 2'b01, 2'b00, 0); pin(2'b01, 2'b00, 2'b00, 1, 0);
        cyc(1, 2'b01, 2'b00, 0); pin(2'b00, 2'b01, 2'b00, 1, 0);
        cyc(1, 2'b01, 2'b00, 1); pin(2'b00, 2'b01, 2'b01, 1, 0);
        cyc(1, 2'b01, 2'b00, 0); pin(2'b01, 2'b00, 2'b00, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b01, 1, 0);
        end
        cyc(1, 2'b00, 2'b00, 0); pin(2'b00, 2'b00, 2'b00, 0, 0);

        // Issue 0,1,0 then flush requester 0; only the id-1 result survives.
        cyc(1, 2'b01, 2'b00, 0); pin(2'b01, 2'b00, 2'b00, 0, 0);
        cyc(1, 2'b10, 2'b00, 0); pin(2'b10, 2'b00, 2'b00, 1, 0);
        cyc(1, 2'b01, 2'b00, 0); pin(2'b01, 2'b00, 2'b00, 1, 0);
        cyc(1, 2'b00, 2'b01, 0); pin(2'b00, 2'b00, 2'b00, 1, 0);
        cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b00, 1, 0);
        cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b10, 1, 0);
        cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b00, 1, 0);
        cyc(1, 2'b00, 2'b00, 0); pin(2'b00, 2'b00, 2'b00, 0, 0);

        // Both request, requester 1 flushed: grant 0, then priority moves to 1.
        cyc(1, 2'b11, 2'b10, 0); pin(2'b01, 2'b00, 2'b00, 0, 0);
        cyc(1, 2'b11, 2'b00, 0); pin(2'b10, 2'b01, 2'b00, 1, 0);
        cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b01, 1, 0);
        cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b10, 1, 0);

        // Flush coinciding with the pop of its own op, and not touching the other's op.
        cyc(1, 2'b10, 2'b00, 0); pin(2'b10, 2'b00, 2'b00, 0, 0);
        cyc(1, 2'b01, 2'b00, 0); pin(2'b01, 2'b00, 2'b00, 1, 0);
        cyc(1, 2'b00, 2'b10, 1); pin(2'b00, 2'b00, 2'b00, 1, 0);
        cyc(1, 2'b00, 2'b10, 1); pin(2'b00, 2'b00, 2'b01, 1, 0);

        // Underflow: sticky error, credits untouched.
        cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b00, 0, 0);
        cyc(1, 2'b00, 2'b00, 0); pin(2'b00, 2'b00, 2'b00, 0, 1);
        cyc(1, 2'b11, 2'b00, 0); pin(2'b10, 2'b01, 2'b00, 0, 1);
        cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b10, 1, 1);

        // Reset with three ops in flight.
        cyc(1, 2'b11, 2'b00, 0); pin(2'b01, 2'b10, 2'b00, 0, 1);
        cyc(1, 2'b11, 2'b00, 0);
        cyc(1, 2'b11, 2'b00, 0); pin(2'b01, 2'b10, 2'b00, 1, 1);
        cyc(0, 2'b11, 2'b00, 0); pin(2'b00, 2'b00, 2'b00, 0, 0);
        cyc(0, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b00, 0, 0);
        cyc(1, 2'b11, 2'b00, 0); pin(2'b01, 2'b10, 2'b00, 0, 0);
        cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b01, 1, 0);
        cyc(1, 2'b00, 2'b00, 1); pin(2'b00, 2'b00, 2'b00, 0, 0);
        cyc(1, 2'b00, 2'b00, 0); pin(2'b00, 2'b00, 2'b00, 0, 1);

        cyc(1, 2'b00, 2'b00, 0);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
